tetris_input_ctrl: RTL

Converts the raw 8-bit USB HID keycode exported by the SoC into discrete Tetris move commands for the game-logic block. It applies delayed auto-shift (DAS) and auto-repeat to held keys and generates the gravity tick. Commands go to the playfield engine over a one-entry valid/ready handshake. The block sits between the SoC `keycode_export` and the game state machine that feeds the VGA renderer.

---
 rtl/tetris_pkg.sv | 47 ++++
 rtl/tetris_key_repeat.sv | 107 ++++++++++
 rtl/tetris_input_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared types, keycode constants and keymap helpers for the Tetris input controller.
package tetris_pkg;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_LEFT  = 3'd1,
        CMD_RIGHT = 3'd2,
        CMD_ROT   = 3'd3,
        CMD_DOWN  = 3'd4,
        CMD_DROP  = 3'd5
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_REPEAT  = 2'd2,
        ST_ONESHOT = 2'd3
    } rep_state_t;

    localparam logic [7:0] KC_NONE  = 8'h00;
    localparam logic [7:0] KC_LEFT  = 8'h04;
    localparam logic [7:0] KC_RIGHT = 8'h07;
    localparam logic [7:0] KC_ROT   = 8'h1A;
    localparam logic [7:0] KC_DOWN  = 8'h16;
    localparam logic [7:0] KC_DROP  = 8'h2C;

    function automatic cmd_t key_to_cmd(input logic [7:0] kc);
        case (kc)
            KC_LEFT:  return CMD_LEFT;
            KC_RIGHT: return CMD_RIGHT;
            KC_ROT:   return CMD_ROT;
            KC_DOWN:  return CMD_DOWN;
            KC_DROP:  return CMD_DROP;
            default:  return CMD_NONE;
        endcase
    endfunction

    // Keys that auto-shift when held; rotate and hard drop fire once per press.
    function automatic logic cmd_repeats(input cmd_t c);
        return (c == CMD_LEFT) || (c == CMD_RIGHT) || (c == CMD_DOWN);
    endfunction

    function automatic logic cmd_resets_gravity(input cmd_t c);
        return (c == CMD_DOWN) || (c == CMD_DROP);
    endfunction

endpackage

// File: rtl/tetris_key_repeat.sv
// Keycode register plus DAS / auto-repeat FSM; emits a one-cycle key_evt with its command.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | no mapped key held
//   ST_HOLD    | repeatable key held, waiting DAS_DELAY for the first repeat
//   ST_REPEAT  | auto-repeating every ARR_PERIOD cycles
//   ST_ONESHOT | non-repeatable key held, no further events until it changes
module tetris_key_repeat
    import tetris_pkg::*;
#(
    parameter int DAS_DELAY  = 8_000_000,
    parameter int ARR_PERIOD = 2_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] keycode,
    output logic       key_evt,
    output logic [2:0] key_cmd
);

    localparam int TMAX = (DAS_DELAY > ARR_PERIOD) ? DAS_DELAY : ARR_PERIOD;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] DAS_TC = TW'(DAS_DELAY - 1);
    localparam logic [TW-1:0] ARR_TC = TW'(ARR_PERIOD - 1);

    rep_state_t    state;
    rep_state_t    state_nx;
    logic [TW-1:0] timer;
    logic          timer_clr;
    logic [7:0]    kc_in;
    logic [7:0]    kc_q;
    logic [7:0]    kc_prev;
    logic          kc_change;
    cmd_t          cur_cmd;
    logic          evt;

    // Unmapped codes collapse to 0x00 so they behave exactly like a release.
    always_comb begin
        kc_in = KC_NONE;
        if (key_to_cmd(keycode) != CMD_NONE) begin
            kc_in = keycode;
        end
    end

    assign kc_change = (kc_q != kc_prev);
    assign cur_cmd   = key_to_cmd(kc_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            kc_q    <= KC_NONE;
            kc_prev <= KC_NONE;
            state   <= ST_IDLE;
            timer   <= '0;
        end else begin
            kc_q    <= kc_in;
            kc_prev <= kc_q;
            state   <= state_nx;
            if (timer_clr) begin
                timer <= '0;
            end else if ((state == ST_HOLD) || (state == ST_REPEAT)) begin
                timer <= timer + TW'(1);
            end else begin
                timer <= '0;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        timer_clr = 1'b0;
        evt       = 1'b0;
        if (kc_change) begin
            // Any change restarts the sequence; a new mapped key fires immediately.
            timer_clr = 1'b1;
            if (cur_cmd == CMD_NONE) begin
                state_nx = ST_IDLE;
            end else begin
                evt      = 1'b1;
                state_nx = cmd_repeats(cur_cmd) ? ST_HOLD : ST_ONESHOT;
            end
        end else begin
            case (state)
                ST_HOLD: begin
                    if (timer == DAS_TC) begin
                        evt       = 1'b1;
                        timer_clr = 1'b1;
                        state_nx  = ST_REPEAT;
                    end
                end
                ST_REPEAT: begin
                    if (timer == ARR_TC) begin
                        evt       = 1'b1;
                        timer_clr = 1'b1;
                    end
                end
                default: begin
                    state_nx = state;
                end
            endcase
        end
    end

    assign key_evt = evt;
    assign key_cmd = cur_cmd;

endmodule

// File: rtl/tetris_input_ctrl.sv
// Tetris input controller top: key repeat, gravity tick and the one-entry command slot.
module tetris_input_ctrl
    import tetris_pkg::*;
#(
    parameter int DAS_DELAY   = 8_000_000,
    parameter int ARR_PERIOD  = 2_500_000,
    parameter int GRAV_PERIOD = 25_000_000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       run,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd
);

    localparam int GW = $clog2(GRAV_PERIOD + 1);
    localparam logic [GW-1:0] GRAV_TC = GW'(GRAV_PERIOD - 1);

    logic          key_evt;
    logic [2:0]    key_cmd_raw;
    cmd_t          key_cmd;
    logic [GW-1:0] grav_cnt;
    logic          grav_pend;
    logic          slot_valid;
    cmd_t          slot_cmd;
    logic          accept;
    logic          slot_free;
    logic          grav_clr;
    logic          grav_wrap;
    logic          grav_load;

    tetris_key_repeat #(
        .DAS_DELAY  (DAS_DELAY),
        .ARR_PERIOD (ARR_PERIOD)
    ) u_key_repeat (
        .clk     (Clk),
        .reset   (Reset),
        .keycode (keycode),
        .key_evt (key_evt),
        .key_cmd (key_cmd_raw)
    );

    assign key_cmd   = cmd_t'(key_cmd_raw);
    assign accept    = slot_valid & cmd_ready;
    assign slot_free = ~slot_valid | accept;
    // Any accepted downward move restarts the gravity period.
    assign grav_clr  = accept & cmd_resets_gravity(slot_cmd);
    assign grav_wrap = run & ~grav_clr & (grav_cnt == GRAV_TC);
    // Key events take the slot first; the pending tick waits for the next free cycle.
    assign grav_load = slot_free & ~key_evt & grav_pend;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            slot_valid <= 1'b0;
            slot_cmd   <= CMD_NONE;
            grav_cnt   <= '0;
            grav_pend  <= 1'b0;
        end else begin
            if (slot_free) begin
                if (key_evt) begin
                    slot_valid <= 1'b1;
                    slot_cmd   <= key_cmd;
                end else if (grav_pend) begin
                    slot_valid <= 1'b1;
                    slot_cmd   <= CMD_DOWN;
                end else begin
                    slot_valid <= 1'b0;
                    slot_cmd   <= CMD_NONE;
                end
            end

            if (!run) begin
                grav_cnt  <= '0;
                grav_pend <= 1'b0;
            end else begin
                grav_pend <= (grav_pend & ~grav_load) | grav_wrap;
                if (grav_clr || grav_wrap) begin
                    grav_cnt <= '0;
                end else begin
                    grav_cnt <= grav_cnt + GW'(1);
                end
            end
        end
    end

    assign cmd_valid = slot_valid;
    assign cmd       = slot_cmd;

endmodule
